// File: rtl/neighbor_scan_pkg.sv
// Shared address map and state encoding for the neighbour scan and winner-policy stages.
// All values (bestvalue, mybest, table values) are unsigned 11.5 fixed point: 11 integer, 5 fraction bits.
package neighbor_scan_pkg;

    localparam int WORD_WIDTH    = 16;
    localparam int MAX_NEIGHBORS = 16;

    localparam logic [WORD_WIDTH-1:0] NEIGHBOR_BASE = 16'h0600;
    localparam logic [WORD_WIDTH-1:0] LIST_BASE     = 16'h0668;
    localparam logic [WORD_WIDTH-1:0] COUNT_ADDR    = 16'h068C;
    localparam logic [WORD_WIDTH-1:0] EPSILON_ADDR  = 16'h0004;
    localparam logic [WORD_WIDTH-1:0] NODE_NONE     = 16'd100;

    localparam logic [WORD_WIDTH-1:0] WORD_STRIDE   = 16'd2;
    localparam logic [WORD_WIDTH-1:0] ENTRY_STRIDE  = 16'd6;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_RD_ID    = 4'd1,
        S_RD_VAL   = 4'd2,
        S_RD_BNID  = 4'd3,
        S_EVAL     = 4'd4,
        S_WR_LIST  = 4'd5,
        S_NEXT     = 4'd6,
        S_WR_COUNT = 4'd7,
        S_DONE     = 4'd8,
        S_WAIT     = 4'd9
    } scan_state_t;

endpackage

// File: rtl/neighbor_scan.sv
// Walks the neighbour table, finds the highest-value entry and writes the list of
// entries better than our own value (plus its count) for the winner-policy stage.
module neighbor_scan
    import neighbor_scan_pkg::*;
(
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  start_scan,
    input  logic [WORD_WIDTH-1:0] neighbor_count,
    input  logic [WORD_WIDTH-1:0] mybest,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic [WORD_WIDTH-1:0] address,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  wr_en,
    output logic [WORD_WIDTH-1:0] besthop,
    output logic [WORD_WIDTH-1:0] bestvalue,
    output logic [WORD_WIDTH-1:0] bestneighborID,
    output logic [WORD_WIDTH-1:0] betterNeighborCount,
    output logic                  done_scan
);

    scan_state_t           r_state;
    logic [WORD_WIDTH-1:0] r_n;
    logic [WORD_WIDTH-1:0] r_mybest;
    logic [WORD_WIDTH-1:0] r_index;
    logic [WORD_WIDTH-1:0] r_entryPtr;
    logic [WORD_WIDTH-1:0] r_id;
    logic [WORD_WIDTH-1:0] r_value;
    logic [WORD_WIDTH-1:0] r_bnid;
    logic [WORD_WIDTH-1:0] r_count;
    logic [WORD_WIDTH-1:0] r_address;
    logic [WORD_WIDTH-1:0] r_dataOut;
    logic                  r_wrEn;
    logic [WORD_WIDTH-1:0] r_besthop;
    logic [WORD_WIDTH-1:0] r_bestvalue;
    logic [WORD_WIDTH-1:0] r_bestnid;
    logic                  r_done;

    scan_state_t           w_stateNext;
    logic [WORD_WIDTH-1:0] w_nNext;
    logic [WORD_WIDTH-1:0] w_mybestNext;
    logic [WORD_WIDTH-1:0] w_indexNext;
    logic [WORD_WIDTH-1:0] w_entryPtrNext;
    logic [WORD_WIDTH-1:0] w_idNext;
    logic [WORD_WIDTH-1:0] w_valueNext;
    logic [WORD_WIDTH-1:0] w_bnidNext;
    logic [WORD_WIDTH-1:0] w_countNext;
    logic [WORD_WIDTH-1:0] w_addressNext;
    logic [WORD_WIDTH-1:0] w_dataOutNext;
    logic                  w_wrEnNext;
    logic [WORD_WIDTH-1:0] w_besthopNext;
    logic [WORD_WIDTH-1:0] w_bestvalueNext;
    logic [WORD_WIDTH-1:0] w_bestnidNext;
    logic                  w_doneNext;

    logic [WORD_WIDTH-1:0] w_nClamped;
    logic [WORD_WIDTH-1:0] w_indexInc;
    logic [WORD_WIDTH-1:0] w_entryPtrInc;

    // Clamping n keeps every read inside the table and the list short of COUNT_ADDR.
    assign w_nClamped    = (neighbor_count > WORD_WIDTH'(MAX_NEIGHBORS))
                           ? WORD_WIDTH'(MAX_NEIGHBORS) : neighbor_count;
    assign w_indexInc    = r_index + 16'd1;
    assign w_entryPtrInc = r_entryPtr + ENTRY_STRIDE;

    always_comb begin
        w_stateNext     = r_state;
        w_nNext         = r_n;
        w_mybestNext    = r_mybest;
        w_indexNext     = r_index;
        w_entryPtrNext  = r_entryPtr;
        w_idNext        = r_id;
        w_valueNext     = r_value;
        w_bnidNext      = r_bnid;
        w_countNext     = r_count;
        w_addressNext   = r_address;
        w_dataOutNext   = r_dataOut;
        w_wrEnNext      = r_wrEn;
        w_besthopNext   = r_besthop;
        w_bestvalueNext = r_bestvalue;
        w_bestnidNext   = r_bestnid;
        w_doneNext      = r_done;

        case (r_state)
            S_IDLE: begin
                if (start_scan) begin
                    w_nNext         = w_nClamped;
                    w_mybestNext    = mybest;
                    w_countNext     = '0;
                    w_indexNext     = '0;
                    w_besthopNext   = NODE_NONE;
                    w_bestvalueNext = '0;
                    w_bestnidNext   = NODE_NONE;
                    w_entryPtrNext  = NEIGHBOR_BASE;
                    w_addressNext   = NEIGHBOR_BASE;
                    if (w_nClamped == '0) begin
                        w_addressNext = COUNT_ADDR;
                        w_dataOutNext = '0;
                        w_wrEnNext    = 1'b1;
                        w_stateNext   = S_WR_COUNT;
                    end else begin
                        w_stateNext   = S_RD_ID;
                    end
                end
            end
            S_RD_ID: begin
                w_idNext      = data_in;
                w_addressNext = r_address + WORD_STRIDE;
                w_stateNext   = S_RD_VAL;
            end
            S_RD_VAL: begin
                w_valueNext   = data_in;
                w_addressNext = r_address + WORD_STRIDE;
                w_stateNext   = S_RD_BNID;
            end
            S_RD_BNID: begin
                w_bnidNext  = data_in;
                w_stateNext = S_EVAL;
            end
            // Strict compare means an equal later entry never displaces an earlier one.
            S_EVAL: begin
                if (r_index == '0 || r_value > r_bestvalue) begin
                    w_besthopNext   = r_id;
                    w_bestvalueNext = r_value;
                    w_bestnidNext   = r_bnid;
                end
                if (r_value > r_mybest) begin
                    w_addressNext = LIST_BASE + (r_count << 1);
                    w_dataOutNext = r_id;
                    w_wrEnNext    = 1'b1;
                    w_stateNext   = S_WR_LIST;
                end else begin
                    w_stateNext   = S_NEXT;
                end
            end
            S_WR_LIST: begin
                w_wrEnNext  = 1'b0;
                w_countNext = r_count + 16'd1;
                w_stateNext = S_NEXT;
            end
            S_NEXT: begin
                w_indexNext    = w_indexInc;
                w_entryPtrNext = w_entryPtrInc;
                if (w_indexInc >= r_n) begin
                    w_addressNext = COUNT_ADDR;
                    w_dataOutNext = r_count;
                    w_wrEnNext    = 1'b1;
                    w_stateNext   = S_WR_COUNT;
                end else begin
                    w_addressNext = w_entryPtrInc;
                    w_stateNext   = S_RD_ID;
                end
            end
            S_WR_COUNT: begin
                w_wrEnNext  = 1'b0;
                w_stateNext = S_DONE;
            end
            S_DONE: begin
                w_doneNext  = 1'b1;
                w_stateNext = S_WAIT;
            end
            S_WAIT: begin
                if (en) begin
                    w_doneNext  = 1'b0;
                    w_stateNext = S_IDLE;
                end
            end
            default: begin
                w_wrEnNext  = 1'b0;
                w_doneNext  = 1'b0;
                w_stateNext = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_n         <= '0;
            r_mybest    <= '0;
            r_index     <= '0;
            r_entryPtr  <= NEIGHBOR_BASE;
            r_id        <= '0;
            r_value     <= '0;
            r_bnid      <= '0;
            r_count     <= '0;
            r_address   <= '0;
            r_dataOut   <= '0;
            r_wrEn      <= 1'b0;
            r_besthop   <= NODE_NONE;
            r_bestvalue <= '0;
            r_bestnid   <= NODE_NONE;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_n         <= w_nNext;
            r_mybest    <= w_mybestNext;
            r_index     <= w_indexNext;
            r_entryPtr  <= w_entryPtrNext;
            r_id        <= w_idNext;
            r_value     <= w_valueNext;
            r_bnid      <= w_bnidNext;
            r_count     <= w_countNext;
            r_address   <= w_addressNext;
            r_dataOut   <= w_dataOutNext;
            r_wrEn      <= w_wrEnNext;
            r_besthop   <= w_besthopNext;
            r_bestvalue <= w_bestvalueNext;
            r_bestnid   <= w_bestnidNext;
            r_done      <= w_doneNext;
        end
    end

    assign address             = r_address;
    assign data_out            = r_dataOut;
    assign wr_en               = r_wrEn;
    assign besthop             = r_besthop;
    assign bestvalue           = r_bestvalue;
    assign bestneighborID      = r_bestnid;
    assign betterNeighborCount = r_count;
    assign done_scan           = r_done;

endmodule
